next_pc_unit: RTL and testbench
===============================

Name: next_pc_unit

Overview:
- Registered program-counter and next-PC selection unit for the MIPS core. It replaces the two-way PC+4/branch-target mux.
- Adds four redirect kinds: beq, bne, jump and jump-register. Also adds stall hold, a post-redirect flush pulse of configurable length, an alignment check and a saturating taken-redirect counter.
- Sits between the fetch stage (drives the instruction-memory address) and decode/execute (sources the branch, jump and ALU-zero information).

Parameters:
- WIDTH, 32, PC/address width in bits; must be >= 32.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- FLUSH_CYCLES, 1, number of cycles flush is held high after an accepted redirect; range 1..15.
- CNT_WIDTH, 16, width of the taken-redirect counter.

Ports:
- clock  input  1  rising-edge system clock.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC and all state this cycle.
- branch  input  1  beq in execute.
- branch_ne  input  1  bne in execute.
- jump  input  1  j/jal in execute.
- jump_reg  input  1  jr in execute.
- alu_zero  input  1  ALU zero flag for the execute instruction.
- branch_target  input  WIDTH  PC+4+(signext(imm)<<2) from the branch adder.
- jump_index  input  26  instr[25:0].
- reg_target  input  WIDTH  rs value for jr.
- pc  output  WIDTH  current PC, registered.
- pc_plus4  output  WIDTH  pc+4, combinational from pc, wraps mod 2^WIDTH.
- flush  output  1  squash younger instructions in the fetch/decode stages.
- align_error  output  1  sticky: a jr to a non-word-aligned target was accepted.
- redirect_count  output  CNT_WIDTH  number of accepted redirects, saturating.

Behaviour:
- Everything updates on the rising edge of clock. reset is synchronous and takes priority over all other inputs.
- Reset values: pc=RESET_PC, flush=0, flush counter=0, align_error=0, redirect_count=0. Reset asserted mid-flush or mid-stall clears all of these on that same edge.
- taken_br = (branch & alu_zero) | (branch_ne & ~alu_zero).
- If branch and branch_ne are both high, only branch is evaluated (beq wins).
- Selection priority: jump_reg > jump > taken_br > sequential.
  - jump_reg target: {reg_target[WIDTH-1:2], 2'b00}.
  - jump target: {pc_plus4[WIDTH-1:28], jump_index, 2'b00}.
  - branch target: branch_target.
  - sequential: pc_plus4.
- Accepted redirect: a non-sequential selection in a cycle with stall=0, reset=0 and flush=0.
- Ignored controls: while flush=1, branch, branch_ne, jump and jump_reg are ignored and pc advances sequentially. These inputs belong to squashed instructions.
- Stall=1:
  - pc, flush, the flush counter, align_error and redirect_count all hold.
  - No redirect is accepted, even if the control inputs are asserted.
  - pc_plus4 still tracks pc.
- Latency: the redirect target appears on pc at the edge where the redirect is accepted, one cycle after the controls are presented.
- Flush counter:
  - An accepted redirect loads FLUSH_CYCLES.
  - flush = (counter != 0), registered, so flush rises on the same edge that pc takes the target.
  - The counter decrements by 1 per non-stalled cycle and stops at 0.
- align_error: set on the edge that accepts a jr with reg_target[1:0] != 0. It stays set until reset. The PC still takes the aligned target.
- redirect_count: increments by 1 per accepted redirect and saturates at all-ones (no wrap).
- Wrap-around: a sequential step from pc = 2^WIDTH-4 goes to 0.
- Simultaneous events: all four controls high → jr wins and the counter increments by exactly 1.

Test Plan:
- Reset then run 3 unstalled cycles with no controls → pc sequence 0x0, 0x4, 0x8, 0xC; flush=0.
- At pc=0x10: branch=1, alu_zero=1, branch_target=0x100 → next pc=0x100, flush=1 for 1 cycle, redirect_count=1.
- At pc=0x10: branch_ne=1, alu_zero=1 → pc=0x14, no flush, count unchanged.
- At pc=0x10: jump_reg=1, reg_target=0x203, jump=1, branch=1, alu_zero=1 → pc=0x200, align_error=1 (sticky), count +1.
- FLUSH_CYCLES=3: jump with jump_index=0x40, then jump asserted again during the flush window → pc=0x100 then 0x104, 0x108, 0x10C; flush high 3 cycles; count=1.
- Hold stall=1 for 2 cycles with branch taken and pc=0x20, then reset asserted while flush=1 → pc stays 0x20 during the stall; after the reset edge pc=RESET_PC, flush=0, count=0, align_error=0.

Source files
------------

// File: rtl/next_pc_unit.sv
// Registered PC with next-PC selection for the MIPS fetch stage. It handles beq/bne/j/jr
// redirects, stall hold, the post-redirect flush window, jr alignment and a redirect counter.
module next_pc_unit #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_PC     = '0,
    parameter int               FLUSH_CYCLES = 1,
    parameter int               CNT_WIDTH    = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stall,
    input  logic                 branch,
    input  logic                 branch_ne,
    input  logic                 jump,
    input  logic                 jump_reg,
    input  logic                 alu_zero,
    input  logic [WIDTH-1:0]     branch_target,
    input  logic [25:0]          jump_index,
    input  logic [WIDTH-1:0]     reg_target,
    output logic [WIDTH-1:0]     pc,
    output logic [WIDTH-1:0]     pc_plus4,
    output logic                 flush,
    output logic                 align_error,
    output logic [CNT_WIDTH-1:0] redirect_count
);

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

    logic [WIDTH-1:0]     pc_q, pc_d;
    logic [3:0]           flush_cnt_q, flush_cnt_d;
    logic                 flush_q, flush_d;
    logic                 align_error_q, align_error_d;
    logic [CNT_WIDTH-1:0] redirect_count_q, redirect_count_d;

    logic                 taken_br;
    logic                 accept;
    logic [WIDTH-1:0]     target;

    assign pc_plus4 = pc_q + WIDTH'(4);

    // beq shadows bne when both are asserted.
    assign taken_br = branch ? alu_zero : (branch_ne & ~alu_zero);

    // Control inputs seen while flushing belong to squashed instructions.
    assign accept = ~stall & ~flush_q & (jump_reg | jump | taken_br);

    always_comb begin
        target = branch_target;
        if (jump_reg) begin
            target = {reg_target[WIDTH-1:2], 2'b00};
        end else if (jump) begin
            target = {pc_plus4[WIDTH-1:28], jump_index, 2'b00};
        end
    end

    always_comb begin
        pc_d             = pc_q;
        flush_cnt_d      = flush_cnt_q;
        flush_d          = flush_q;
        align_error_d    = align_error_q;
        redirect_count_d = redirect_count_q;
        if (!stall) begin
            if (accept) begin
                pc_d        = target;
                flush_cnt_d = FLUSH_LOAD;
                if (jump_reg && (reg_target[1:0] != 2'b00)) begin
                    align_error_d = 1'b1;
                end
                if (redirect_count_q != '1) begin
                    redirect_count_d = redirect_count_q + CNT_WIDTH'(1);
                end
            end else begin
                pc_d        = pc_plus4;
                flush_cnt_d = (flush_cnt_q != 4'd0) ? flush_cnt_q - 4'd1 : 4'd0;
            end
            flush_d = (flush_cnt_d != 4'd0);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q             <= RESET_PC;
            flush_cnt_q      <= 4'd0;
            flush_q          <= 1'b0;
            align_error_q    <= 1'b0;
            redirect_count_q <= '0;
        end else begin
            pc_q             <= pc_d;
            flush_cnt_q      <= flush_cnt_d;
            flush_q          <= flush_d;
            align_error_q    <= align_error_d;
            redirect_count_q <= redirect_count_d;
        end
    end

    assign pc             = pc_q;
    assign flush          = flush_q;
    assign align_error    = align_error_q;
    assign redirect_count = redirect_count_q;

endmodule

// File: tb/tb_next_pc_unit.sv
// Bench for next_pc_unit: vector table, hand sequences and random stimulus vs a reference model.
// Two instances share stimulus: default parameters, and a 3-cycle flush / 4-bit counter variant.
module tb_next_pc_unit;

    logic        clock;
    logic        reset, stall, branch, branch_ne, jump, jump_reg, alu_zero;
    logic [31:0] branch_target, reg_target;
    logic [25:0] jump_index;

    logic [31:0] pc1, pc4_1, pc3, pc4_3;
    logic        fl1, ae1, fl3, ae3;
    logic [15:0] cnt1;
    logic [3:0]  cnt3;

    int checks   = 0;
    int failures = 0;

    next_pc_unit dut (
        .clock(clock), .reset(reset), .stall(stall), .branch(branch), .branch_ne(branch_ne),
        .jump(jump), .jump_reg(jump_reg), .alu_zero(alu_zero), .branch_target(branch_target),
        .jump_index(jump_index), .reg_target(reg_target), .pc(pc1), .pc_plus4(pc4_1),
        .flush(fl1), .align_error(ae1), .redirect_count(cnt1)
    );

    next_pc_unit #(.FLUSH_CYCLES(3), .CNT_WIDTH(4)) dut3 (
        .clock(clock), .reset(reset), .stall(stall), .branch(branch), .branch_ne(branch_ne),
        .jump(jump), .jump_reg(jump_reg), .alu_zero(alu_zero), .branch_target(branch_target),
        .jump_index(jump_index), .reg_target(reg_target), .pc(pc3), .pc_plus4(pc4_3),
        .flush(fl3), .align_error(ae3), .redirect_count(cnt3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference model: PC, remaining flush cycles, sticky error, redirect tally.
    typedef struct {
        logic [31:0] pc;
        int          fl;
        bit          ae;
        int          cnt;
    } mstate_t;

    mstate_t m1, m3;

    function automatic mstate_t mstep(mstate_t s, int fc, int cmax);
        mstate_t     n = s;
        logic [31:0] seq;
        bit          taken;
        bit          redir;
        if (reset) begin
            n.pc = 32'h0; n.fl = 0; n.ae = 0; n.cnt = 0;
            return n;
        end
        if (stall) return n;
        seq = s.pc + 32'd4;
        if (s.fl > 0) begin
            n.pc = seq;
            n.fl = s.fl - 1;
            return n;
        end
        if (branch) taken = alu_zero;
        else        taken = branch_ne && !alu_zero;
        redir = 1'b1;
        if (jump_reg) begin
            n.pc = reg_target & ~32'd3;
            if ((reg_target % 4) != 0) n.ae = 1;
        end else if (jump) begin
            n.pc = (seq & 32'hF000_0000) | (32'(jump_index) * 4);
        end else if (taken) begin
            n.pc = branch_target;
        end else begin
            n.pc = seq;
            redir = 1'b0;
        end
        if (redir) begin
            n.fl = fc;
            if (s.cnt < cmax) n.cnt = s.cnt + 1;
        end
        return n;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        reset = 0; stall = 0; branch = 0; branch_ne = 0; jump = 0; jump_reg = 0;
        alu_zero = 0; branch_target = 32'h0; jump_index = 26'h0; reg_target = 32'h0;
    endtask

    task automatic tick();
        m1 = mstep(m1, 1, 65535);
        m3 = mstep(m3, 3, 15);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        reset = 0;
    endtask

    typedef struct {
        bit          stl, br, bne, j, jr, z;
        logic [31:0] bt;
        logic [25:0] ji;
        logic [31:0] rt;
        logic [31:0] epc;
        bit          efl;
        int          ecnt;
        bit          eae;
    } vec_t;

    function automatic vec_t mk(bit stl, bit br, bit bne, bit j, bit jr, bit z,
                                logic [31:0] bt, logic [25:0] ji, logic [31:0] rt,
                                logic [31:0] epc, bit efl, int ecnt, bit eae);
        vec_t v;
        v.stl = stl; v.br = br; v.bne = bne; v.j = j; v.jr = jr; v.z = z;
        v.bt = bt; v.ji = ji; v.rt = rt; v.epc = epc; v.efl = efl; v.ecnt = ecnt; v.eae = eae;
        return v;
    endfunction

    vec_t vecs[15];

    initial begin
        //              stl br bne j jr z  bt            ji        rt            pc            fl cnt ae
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,    32'h0,        32'h4,        0, 0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,    32'h0,        32'h8,        0, 0, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,    32'h0,        32'hC,        0, 0, 0);
        vecs[3]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,    32'h0,        32'h10,       0, 0, 0);
        vecs[4]  = mk(0, 1, 0, 0, 0, 1, 32'h100,      26'h0,    32'h0,        32'h100,      1, 1, 0);
        vecs[5]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,    32'h0,        32'h104,      0, 1, 0);
        vecs[6]  = mk(0, 0, 1, 0, 0, 1, 32'h300,      26'h0,    32'h0,        32'h108,      0, 1, 0);
        vecs[7]  = mk(0, 0, 1, 0, 0, 0, 32'h300,      26'h0,    32'h0,        32'h300,      1, 2, 0);
        vecs[8]  = mk(0, 0, 0, 1, 0, 0, 32'h0,        26'h55,   32'h0,        32'h304,      0, 2, 0);
        vecs[9]  = mk(0, 1, 1, 0, 0, 0, 32'h500,      26'h0,    32'h0,        32'h308,      0, 2, 0);
        vecs[10] = mk(0, 1, 0, 1, 1, 1, 32'h700,      26'h99,   32'h203,      32'h200,      1, 3, 1);
        vecs[11] = mk(1, 1, 0, 0, 0, 1, 32'h999,      26'h0,    32'h0,        32'h200,      1, 3, 1);
        vecs[12] = mk(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,    32'h0,        32'h204,      0, 3, 1);
        vecs[13] = mk(0, 0, 0, 1, 0, 0, 32'h0,        26'h40,   32'h0,        32'h100,      1, 4, 1);
        vecs[14] = mk(0, 0, 0, 0, 0, 0, 32'h0,        26'h0,    32'h0,        32'h104,      0, 4, 1);

        idle();
        m1 = '{32'h0, 0, 0, 0};
        m3 = '{32'h0, 0, 0, 0};
        #2;
        do_reset();
        check("reset_pc", pc1, 32'h0);
        check("reset_flush", fl1, 0);
        check("reset_cnt", cnt1, 0);
        check("reset_ae", ae1, 0);
        check("reset_pc_plus4", pc4_1, 32'h4);

        // Vector table on the default instance
        for (int i = 0; i < 15; i++) begin
            idle();
            stall = vecs[i].stl; branch = vecs[i].br; branch_ne = vecs[i].bne;
            jump = vecs[i].j; jump_reg = vecs[i].jr; alu_zero = vecs[i].z;
            branch_target = vecs[i].bt; jump_index = vecs[i].ji; reg_target = vecs[i].rt;
            tick();
            $display("vec %0d: pc=0x%0h flush=%0d cnt=%0d ae=%0d", i, pc1, fl1, cnt1, ae1);
            check($sformatf("vec%0d_pc", i), pc1, vecs[i].epc);
            check($sformatf("vec%0d_flush", i), fl1, vecs[i].efl);
            check($sformatf("vec%0d_cnt", i), cnt1, 64'(vecs[i].ecnt));
            check($sformatf("vec%0d_ae", i), ae1, vecs[i].eae);
        end

        // Three-cycle flush window: a second jump inside the window is ignored
        do_reset();
        idle(); jump = 1; jump_index = 26'h40; tick();
        check("f3_pc0", pc3, 32'h100); check("f3_fl0", fl3, 1);
        idle(); jump = 1; jump_index = 26'h80; tick();
        check("f3_pc1", pc3, 32'h104); check("f3_fl1", fl3, 1);
        idle(); tick();
        check("f3_pc2", pc3, 32'h108); check("f3_fl2", fl3, 1);
        idle(); tick();
        check("f3_pc3", pc3, 32'h10C); check("f3_fl3", fl3, 0);
        check("f3_cnt", cnt3, 1);
        $display("flush3 seq: pc=0x%0h cnt=%0d", pc3, cnt3);

        // Stall holds everything, then reset mid-stall and mid-flush clears it
        do_reset();
        idle(); jump_reg = 1; reg_target = 32'h21; tick();
        check("st_pc0", pc1, 32'h20); check("st_ae0", ae1, 1); check("st_fl0", fl1, 1);
        for (int k = 0; k < 2; k++) begin
            idle(); stall = 1; branch = 1; alu_zero = 1; branch_target = 32'h400; tick();
            check($sformatf("st_hold_pc%0d", k), pc1, 32'h20);
            check($sformatf("st_hold_fl%0d", k), fl1, 1);
            check($sformatf("st_hold_cnt%0d", k), cnt1, 1);
            check($sformatf("st_hold_pc4_%0d", k), pc4_1, 32'h24);
        end
        idle(); stall = 1; reset = 1; tick(); reset = 0;
        check("st_rst_pc", pc1, 32'h0); check("st_rst_fl", fl1, 0);
        check("st_rst_cnt", cnt1, 0); check("st_rst_ae", ae1, 0);
        check("st_rst_pc3", pc3, 32'h0); check("st_rst_fl3", fl3, 0);
        $display("stall/reset seq: pc=0x%0h flush=%0d", pc1, fl1);

        // Wrap-around from the top word of the address space
        idle(); jump_reg = 1; reg_target = 32'hFFFF_FFFC; tick();
        check("wrap_pc_top", pc1, 32'hFFFF_FFFC); check("wrap_pc4", pc4_1, 32'h0);
        idle(); tick();
        check("wrap_pc0", pc1, 32'h0);
        $display("wrap seq: pc=0x%0h", pc1);

        // Counter saturation on the 4-bit instance
        do_reset();
        for (int k = 0; k < 20; k++) begin
            idle(); jump = 1; jump_index = 26'h10; tick();
            idle(); tick(); tick(); tick();
        end
        check("sat_cnt3", cnt3, 15);
        check("sat_cnt1", cnt1, 20);
        $display("saturation seq: cnt3=%0d cnt1=%0d", cnt3, cnt1);

        // Random stimulus against the model
        for (int k = 0; k < 3000; k++) begin
            idle();
            reset     = ($urandom_range(0, 99) < 2);
            stall     = ($urandom_range(0, 99) < 20);
            branch    = ($urandom_range(0, 99) < 20);
            branch_ne = ($urandom_range(0, 99) < 20);
            jump      = ($urandom_range(0, 99) < 10);
            jump_reg  = ($urandom_range(0, 99) < 8);
            alu_zero  = $urandom_range(0, 1);
            branch_target = $urandom & 32'hFFFF_FFFC;
            jump_index    = 26'($urandom);
            reg_target    = $urandom;
            tick();
            check("rnd_pc1", pc1, m1.pc);
            check("rnd_pc4_1", pc4_1, m1.pc + 32'd4);
            check("rnd_fl1", fl1, m1.fl > 0);
            check("rnd_ae1", ae1, m1.ae);
            check("rnd_cnt1", cnt1, 64'(m1.cnt));
            check("rnd_pc3", pc3, m3.pc);
            check("rnd_fl3", fl3, m3.fl > 0);
            check("rnd_ae3", ae3, m3.ae);
            check("rnd_cnt3", cnt3, 64'(m3.cnt));
            if (k % 500 == 0)
                $display("rnd %0d: pc=0x%0h flush=%0d cnt=%0d", k, pc1, fl1, cnt1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
